// File: rtl/cic_pkg.sv
// Shared CIC filter parameters, common to the interpolator and the decimator.
package cic_pkg;
  localparam int NUM_STAGES = 3;
  localparam int STG_GSZ    = 5;
  localparam int ISZ        = 16;
  localparam int OSZ        = ISZ + (NUM_STAGES - 1) * STG_GSZ;
  localparam int R          = 1 << STG_GSZ;
endpackage

// File: rtl/cic_comb.sv
// One gated comb stage: diff <= x - dly, dly <= x on enabled clocks, hold otherwise.
module cic_comb
  import cic_pkg::*;
#(
  parameter int W = OSZ
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  input  logic signed [W-1:0] x_i,
  output logic signed [W-1:0] diff_o
);

  logic signed [W-1:0] dly_q, dly_d;
  logic signed [W-1:0] diff_q, diff_d;

  always_comb begin
    dly_d  = dly_q;
    diff_d = diff_q;
    if (en_i) begin
      diff_d = x_i - dly_q;
      dly_d  = x_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dly_q  <= '0;
      diff_q <= '0;
    end else begin
      dly_q  <= dly_d;
      diff_q <= diff_d;
    end
  end

  assign diff_o = diff_q;

endmodule

// File: rtl/cic_interpolator.sv
// CIC interpolator: gated comb chain at the input rate, zero-stuffing upsampler,
// integrator cascade at the output rate, all on the single output-rate clock.
module cic_interpolator #(
  parameter int NUM_STAGES = cic_pkg::NUM_STAGES,
  parameter int STG_GSZ    = cic_pkg::STG_GSZ,
  parameter int ISZ        = cic_pkg::ISZ,
  parameter int OSZ        = ISZ + (NUM_STAGES - 1) * STG_GSZ
) (
  input  logic                  out_clk_i,
  input  logic                  reset_i,
  input  logic                  enable_i,
  input  logic signed [ISZ-1:0] in_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic                  underrun_clr_i,
  output logic signed [OSZ-1:0] out_o,
  output logic                  out_valid_o,
  output logic                  underrun_o
);
  import cic_pkg::*;

  logic [STG_GSZ-1:0]    phase_q, phase_d;
  logic [NUM_STAGES:0]   en_q, en_d;
  logic signed [OSZ-1:0] slot_x_q, slot_x_d;
  logic signed [OSZ-1:0] integ_q [NUM_STAGES];
  logic signed [OSZ-1:0] integ_d [NUM_STAGES];
  logic signed [OSZ-1:0] comb_x  [NUM_STAGES];
  logic signed [OSZ-1:0] comb_y  [NUM_STAGES];
  logic signed [OSZ-1:0] up;
  logic                  underrun_q, underrun_d;
  logic                  out_valid_q;
  logic                  slot_take;

  assign slot_take  = enable_i && (phase_q == '0);
  assign in_ready_o = slot_take && !reset_i;

  // en_q[k] marks that comb k fires on the coming edge; en_q[NUM_STAGES] marks the
  // single clock per slot on which the last comb output reaches the integrators.
  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_comb
    if (k == 0) begin : g_first
      assign comb_x[k] = slot_x_q;
    end else begin : g_next
      assign comb_x[k] = comb_y[k-1];
    end

    cic_comb #(.W(OSZ)) u_comb (
      .clk_i  (out_clk_i),
      .rst_i  (reset_i),
      .en_i   (en_q[k] && enable_i),
      .x_i    (comb_x[k]),
      .diff_o (comb_y[k])
    );
  end

  always_comb begin
    phase_d    = phase_q;
    en_d       = en_q;
    slot_x_d   = slot_x_q;
    underrun_d = underrun_q;
    integ_d    = integ_q;
    up         = '0;

    if (en_q[NUM_STAGES]) up = comb_y[NUM_STAGES-1];

    if (enable_i) begin
      phase_d = phase_q + 1'b1;
      en_d    = {en_q[NUM_STAGES-1:0], slot_take};
      if (slot_take) begin
        slot_x_d = in_valid_i ? OSZ'(in_i) : '0;
      end
      integ_d[0] = integ_q[0] + up;
      for (int i = 1; i < NUM_STAGES; i++) begin
        integ_d[i] = integ_q[i] + integ_q[i-1];
      end
    end

    // A missed slot in the same cycle as a clear must leave the flag set.
    if (slot_take && !in_valid_i) begin
      underrun_d = 1'b1;
    end else if (underrun_clr_i) begin
      underrun_d = 1'b0;
    end
  end

  always_ff @(posedge out_clk_i or posedge reset_i) begin
    if (reset_i) begin
      phase_q     <= '0;
      en_q        <= '0;
      slot_x_q    <= '0;
      underrun_q  <= 1'b0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < NUM_STAGES; i++) integ_q[i] <= '0;
    end else begin
      phase_q     <= phase_d;
      en_q        <= en_d;
      slot_x_q    <= slot_x_d;
      underrun_q  <= underrun_d;
      out_valid_q <= enable_i;
      for (int i = 0; i < NUM_STAGES; i++) integ_q[i] <= integ_d[i];
    end
  end

  assign out_o       = integ_q[NUM_STAGES-1];
  assign out_valid_o = out_valid_q;
  assign underrun_o  = underrun_q;

endmodule

// File: tb/tb_cic_interpolator.sv
// Self-checking bench for cic_interpolator against a closed-form CIC reference model.
module tb_cic_interpolator;
  import cic_pkg::*;

  logic                  clk;
  logic                  rst;
  logic                  en;
  logic signed [ISZ-1:0] din;
  logic                  din_v;
  logic                  rdy;
  logic                  clr;
  logic signed [OSZ-1:0] dout;
  logic                  dout_v;
  logic                  ur;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: accepted slot values and count of enabled edges since reset.
  longint xs[$];
  longint k_en;
  logic   m_ur;
  logic   m_ov;

  cic_interpolator dut (
    .out_clk_i      (clk),
    .reset_i        (rst),
    .enable_i       (en),
    .in_i           (din),
    .in_valid_i     (din_v),
    .in_ready_o     (rdy),
    .underrun_clr_i (clr),
    .out_o          (dout),
    .out_valid_o    (dout_v),
    .underrun_o     (ur)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic longint xv(int n);
    if (n < 0 || n >= xs.size()) return 0;
    return xs[n];
  endfunction

  // Each slot contributes its third difference once, delayed 4 edges after the slot edge,
  // passed through three cascaded accumulators: a C(d,2) weighting of that impulse.
  function automatic logic [OSZ-1:0] exp_out();
    longint acc = 0;
    longint c, d;
    for (int n = 0; n < xs.size(); n++) begin
      c = xv(n) - 3 * xv(n-1) + 3 * xv(n-2) - xv(n-3);
      d = k_en - 5 - longint'(R) * n;
      if (d >= 2) acc += c * ((d * (d - 1)) / 2);
    end
    return acc[OSZ-1:0];
  endfunction

  function automatic logic exp_rdy();
    return en && ((k_en % R) == 0);
  endfunction

  task automatic model_clear();
    xs.delete();
    k_en = 0;
    m_ur = 1'b0;
    m_ov = 1'b0;
  endtask

  task automatic drive(input logic e, input logic v, input logic signed [ISZ-1:0] d,
                       input logic c);
    en = e; din_v = v; din = d; clr = c;
  endtask

  task automatic tick();
    if (en) begin
      if ((k_en % R) == 0) begin
        xs.push_back(din_v ? longint'(din) : 0);
        if (!din_v) m_ur = 1'b1;
        else if (clr) m_ur = 1'b0;
      end else if (clr) m_ur = 1'b0;
      k_en++;
    end else if (clr) m_ur = 1'b0;
    m_ov = en;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, '0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, 16'sd7, 1'b0);
    rst = 1'b1;
    #2;
    n_cmp++;
    if (dout !== '0 || dout_v !== 1'b0 || ur !== 1'b0 || rdy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: out=%0d ov=%b ur=%b rdy=%b, required all 0", dout, dout_v, ur, rdy);
    end
    do_reset();
  endtask

  task automatic test_impulse(input string tag);
    logic [OSZ-1:0] e;
    for (int c = 0; c < 3 * R; c++) begin
      drive(1'b1, 1'b1, (c == 0) ? 16'sd1 : 16'sd0, 1'b0);
      tick();
      e = exp_out();
      n_cmp++;
      if (dout !== e || dout_v !== 1'b1) begin
        n_bad++;
        $display("FAIL %s_out k=%0d: got %0d ov=%b, required %0d ov=1", tag, k_en, dout, dout_v, $signed(e));
      end
      if (k_en == 6 || k_en == 7 || k_en == 38) begin
        n_cmp++;
        if (dout !== ((k_en == 6) ? OSZ'(0) : (k_en == 7) ? OSZ'(1) : OSZ'(528))) begin
          n_bad++;
          $display("FAIL %s_point k=%0d: got %0d", tag, k_en, dout);
        end
      end
    end
  endtask

  task automatic test_dc(input logic signed [ISZ-1:0] val, input logic [OSZ-1:0] settle);
    logic [OSZ-1:0] e;
    do_reset();
    for (int c = 0; c < 8 * R; c++) begin
      drive(1'b1, 1'b1, val, 1'b0);
      tick();
      e = exp_out();
      n_cmp++;
      if (dout !== e) begin
        n_bad++;
        $display("FAIL dc_out val=%0d k=%0d: got %0d, required %0d", val, k_en, dout, $signed(e));
      end
    end
    n_cmp++;
    if (dout !== settle) begin
      n_bad++;
      $display("FAIL dc_settle val=%0d: got %0d, required %0d", val, dout, $signed(settle));
    end
  endtask

  task automatic test_underrun();
    do_reset();
    for (int c = 0; c < 3 * R; c++) begin
      drive(1'b1, !(c == R), 16'sd50, (c == R + 5) || (c == 2 * R));
      if (c == 2 * R) din_v = 1'b0;
      tick();
      n_cmp++;
      if (ur !== m_ur || dout !== exp_out()) begin
        n_bad++;
        $display("FAIL underrun k=%0d: ur=%b out=%0d, required ur=%b out=%0d", k_en, ur, dout, m_ur, $signed(exp_out()));
      end
      if (c == R || c == R + 5 || c == 2 * R) begin
        n_cmp++;
        if (ur !== ((c == R + 5) ? 1'b0 : 1'b1)) begin
          n_bad++;
          $display("FAIL underrun_point c=%0d: got %b", c, ur);
        end
      end
    end
  endtask

  task automatic test_enable_gap();
    logic [OSZ-1:0] e;
    do_reset();
    for (int c = 0; c < 4 * R + 10; c++) begin
      drive(!(c >= 45 && c < 55), 1'b1, 16'($urandom), 1'b0);
      tick();
      e = exp_out();
      n_cmp++;
      if (dout !== e || dout_v !== m_ov) begin
        n_bad++;
        $display("FAIL enable_gap c=%0d: out=%0d ov=%b, required %0d ov=%b", c, dout, dout_v, $signed(e), m_ov);
      end
    end
  endtask

  task automatic test_random();
    logic [OSZ-1:0] e;
    logic           re;
    do_reset();
    for (int c = 0; c < 25 * R; c++) begin
      drive($urandom_range(0, 9) != 0, $urandom_range(0, 9) != 0, 16'($urandom),
            $urandom_range(0, 19) == 0);
      #1;
      re = exp_rdy();
      n_cmp++;
      if (rdy !== re) begin
        n_bad++;
        $display("FAIL in_ready c=%0d: got %b, required %b", c, rdy, re);
      end
      tick();
      e = exp_out();
      n_cmp++;
      if (dout !== e || dout_v !== m_ov || ur !== m_ur) begin
        n_bad++;
        $display("FAIL random c=%0d: out=%0d ov=%b ur=%b, required %0d ov=%b ur=%b",
                 c, dout, dout_v, ur, $signed(e), m_ov, m_ur);
      end
    end
  endtask

  task automatic test_async_reset();
    for (int c = 0; c < 50; c++) begin
      drive(1'b1, c != 32, 16'($urandom), 1'b0);
      tick();
    end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (dout !== '0 || dout_v !== 1'b0 || ur !== 1'b0 || rdy !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset: out=%0d ov=%b ur=%b rdy=%b, required all 0", dout, dout_v, ur, rdy);
    end
    #1;
    rst = 1'b0;
    model_clear();
    test_impulse("post_reset_impulse");
  endtask

  initial begin
    rst = 1'b0;
    drive(1'b0, 1'b0, '0, 1'b0);
    model_clear();
    @(posedge clk);
    #1;
    test_reset();
    test_impulse("impulse");
    test_dc(16'sd100, OSZ'(102400));
    test_dc(-16'sd32768, OSZ'(-33554432));
    test_underrun();
    test_enable_gap();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cic_interpolator.md
CIC_INTERPOLATOR -- requirements
Module: cic_interpolator

Interface
REQ-001 Parameter: NUM_STAGES, 3, number of comb and integrator stages.
REQ-002 Parameter: STG_GSZ, 5, log2 of interpolation ratio R (R = 32).
REQ-003 Parameter: ISZ, 16, input word size.
REQ-004 Parameter: OSZ, ISZ + (NUM_STAGES - 1) * STG_GSZ = 26, output and internal word size.
REQ-005 out_clk  input  1  single clock, runs at the output sample rate; one clock, no other clock domain.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 enable  input  1  run enable; low freezes all state.
REQ-008 in  input  ISZ  signed input sample.
REQ-009 in_valid  input  1  input sample present.
REQ-010 in_ready  output  1  block accepts a sample this cycle.
REQ-011 underrun_clr  input  1  clears the underrun flag.
REQ-012 out  output  OSZ  signed interpolated output.
REQ-013 out_valid  output  1  out holds a valid sample.
REQ-014 underrun  output  1  sticky flag: sample slot found in_valid low.

Function
REQ-015 Phase counter SHALL be STG_GSZ bits wide, SHALL increment on each clock with enable high, and SHALL wrap from R-1 to 0.
REQ-016 in_ready SHALL equal enable AND (phase == 0), combinationally; a transfer occurs when in_valid and in_ready are both high.
REQ-017 The phase-0 slot SHALL take the comb input as sign-extended in when in_valid is high, and as 0 when in_valid is low; a 0 slot SHALL set underrun.
REQ-018 Comb stage k (1..NUM_STAGES) SHALL compute diff <= x - dly and dly <= x on the edge k clocks after the slot edge, and SHALL hold at all other times; the enables are a shift chain gated by enable.
REQ-019 The upsampler SHALL feed the last comb output to integrator 0 for exactly one enabled clock per slot, and 0 for the other R-1 clocks.
REQ-020 Integrator i SHALL update on every enabled clock: integrator[i] <= integrator[i] + input; integrator 0 takes the upsampler output and integrator i>0 takes integrator[i-1].
REQ-021 All arithmetic SHALL use OSZ bits in two's complement with modular wrap; no saturation.
REQ-022 out SHALL equal integrator[NUM_STAGES-1]; a sample accepted at edge t SHALL first affect out at edge t + 2*NUM_STAGES (6).
REQ-023 out_valid SHALL be enable registered once.
REQ-024 DC gain SHALL be R^(NUM_STAGES-1) = 1024.
REQ-025 With enable low, phase, combs, integrators and underrun set logic SHALL hold, and out_valid SHALL drop on the next edge.
REQ-026 When an underrun set and underrun_clr occur in the same cycle, set SHALL win.

Reset
REQ-027 Asserting reset SHALL immediately clear phase, comb diff/dly, comb enables, integrators, out_valid and underrun to 0; in_ready SHALL be low while reset is high.
REQ-028 Reset asserted mid-operation SHALL discard all in-flight samples; after release, the first slot SHALL occur at the first enabled edge (phase 0).

Structure
REQ-029 Package cic_pkg SHALL hold NUM_STAGES, STG_GSZ, ISZ, OSZ and R, shared with the decimator.
REQ-030 One sub-module, cic_comb (single gated comb stage: diff/dly pair with enable), SHALL be instantiated NUM_STAGES times.

Verification
REQ-031 Impulse: in = 1 in one slot, then 0 with in_valid high -> out = 0 until edge t+6, then 1, 3, 6, 10, ... with 528 on the 32nd output.
REQ-032 DC: in = 100 in every slot -> out settles to 102400; in = -32768 -> out settles to -33554432 with no wrap error.
REQ-033 Underrun: in_valid low at one phase-0 slot -> underrun = 1 and that slot is treated as 0; underrun_clr pulse -> 0; simultaneous set and clr -> stays 1.
REQ-034 Enable gap: enable low for 10 clocks mid-stream -> out_valid low, out frozen; output sequence after resume equals the gap-free sequence shifted by 10.
REQ-035 Async reset mid-stream: reset pulse between edges -> all outputs 0 immediately; post-release impulse response matches REQ-031.
